hc595_rx: RTL and testbench
===========================

HC595_RX -- requirements
Module: hc595_rx

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 16, bits per 595 frame (layout {1'b0, seg[6:0], sel[7:0]}).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on each serial input (range 2..3).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-004 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port sh_cp  input  1  shift clock from the 595 driver (asynchronous to clk).
REQ-006 SHALL have port st_cp  input  1  storage/latch clock from the 595 driver (asynchronous to clk).
REQ-007 SHALL have port ds  input  1  serial data, MSB first.
REQ-008 SHALL have port par_data  output  FRAME_BITS  last latched frame.
REQ-009 SHALL have port par_valid  output  1  one-cycle pulse when par_data updates.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse, coincident with par_valid, when the bit count is not FRAME_BITS.
REQ-011 SHALL have port disp_data  output  32  reconstructed 8-digit hex value; digit i in bits [4i+3:4i].
REQ-012 SHALL have port disp_valid  output  1  one-cycle pulse when all 8 digits have been refreshed.
REQ-013 SHALL have port decode_err  output  1  one-cycle pulse when a latched frame is not decodable.

Function
REQ-014 SHALL pass sh_cp, st_cp and ds through SYNC_STAGES flops each; all logic uses the synchronized copies only.
REQ-015 SHALL detect rising edges of synchronized sh_cp/st_cp with one extra history flop; ds is sampled at the same pipeline stage as the sh_cp edge.
REQ-016 SHALL, on a sh_cp rise, shift: shreg <= {shreg[FRAME_BITS-2:0], ds}; bit counter increments, saturating at FRAME_BITS+1.
REQ-017 SHALL, on a st_cp rise, load par_data <= shreg; par_valid pulses in the following cycle (latency: 1 clk after the detected edge).
REQ-018 SHALL assert frame_err with par_valid when the bit count is not FRAME_BITS (short frame, or over-long frame at saturation); par_data is still updated.
REQ-019 SHALL, on a st_cp rise, clear the bit counter to 0.
REQ-020 SHALL, on simultaneous sh_cp and st_cp rises, latch the pre-shift shreg (595 semantics), perform the shift, and set the counter to 1.
REQ-021 SHALL decode each latched frame one cycle after par_valid: sel is one-hot active-high (bit i = digit i); seg is active-low gfedcba.
REQ-022 SHALL map seg to a nibble by this table: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
REQ-023 SHALL, on a valid decode, write nibble to disp_data[4i+3:4i] and set seen[i].
REQ-024 SHALL pulse decode_err and leave disp_data/seen unchanged when sel is not one-hot, seg is not in the table, frame_err was set, or bit 15 is 1.
REQ-025 SHALL, when seen becomes 8'hFF, pulse disp_valid in that update cycle and clear seen in the same cycle; repeated digits before completion overwrite without error.
REQ-026 SHALL never assert par_valid, disp_valid or decode_err for more than one consecutive cycle per st_cp edge.

Reset
REQ-027 SHALL, while reset_n=0 at a clk edge, clear synchronizers, edge-history flops, shreg, counter, par_data, disp_data and seen to 0, and drive all pulse outputs to 0.
REQ-028 SHALL discard a partially shifted frame on reset; the first st_cp after reset with fewer than FRAME_BITS shifts gives frame_err.
REQ-029 SHALL ignore edges whose synchronizer history spans reset release; an input held high through reset release produces no edge.

Structure
REQ-030 SHALL take FRAME_BITS default, the 16-entry glyph table and the sel/seg bit positions from the shared package hc595_pkg, which is also used by the 595 driver side.
REQ-031 SHALL contain one combinational sub-module, seg7_decode (seg[6:0] -> nibble, hit flag), instantiated once.

Verification
REQ-032 SHALL check a normal frame: shift 16'h4001 MSB first, then pulse st_cp -> par_data=16'h4001, par_valid one pulse, frame_err=0, disp_data[3:0]=0.
REQ-033 SHALL check a full scan of 32'h01234567 driven through the driver (8 frames) -> disp_valid one pulse, disp_data=32'h01234567, no errors.
REQ-034 SHALL check a short frame: 15 shifts, then st_cp -> par_valid with frame_err=1, decode_err=1, disp_data unchanged.
REQ-035 SHALL check a bad glyph: frame {0, 7'h7F, 8'h01} -> decode_err=1, seen unchanged.
REQ-036 SHALL check simultaneous sh_cp/st_cp rising in the same clk -> the latch holds the pre-shift value and the counter is 1.
REQ-037 SHALL check reset mid-frame: 8 shifts, reset_n=0 for 1 clk, then 16 shifts and st_cp -> clean frame, no frame_err.

Source files
------------

// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 driver and receiver.
// Frame layout, glyph table and display geometry.
package hc595_pkg;

    localparam int FRAME_BITS_DEF = 16;
    localparam int DIGITS         = 8;
    localparam int NIB_W          = 4;
    localparam int SEG_W          = 7;
    localparam int SEL_W          = 8;

    // Bit positions of one frame: pad at 15, seg at [14:8], sel at [7:0].
    typedef struct packed {
        logic             pad;
        logic [SEG_W-1:0] seg;
        logic [SEL_W-1:0] sel;
    } frame_t;

    // Active-low gfedcba pattern for each hex digit.
    function automatic logic [SEG_W-1:0] glyph(input logic [NIB_W-1:0] n);
        logic [SEG_W-1:0] g;
        unique case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hc595_rx_seg7_decode.sv
// Reverse glyph lookup: segment pattern to hex nibble.
// hit is low when the pattern is not one of the 16 glyphs.
module seg7_decode
    import hc595_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [NIB_W-1:0] nib,
    output logic             hit
);

    // Search the glyph table for a matching pattern.
    always_comb begin
        nib = '0;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == glyph(NIB_W'(i))) begin
                nib = NIB_W'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hc595_rx.sv
// Sniffs the serial 595 bus, rebuilds frames and the
// 8-digit hex value shown on the multiplexed display.
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sh_cp,
    input  logic                  st_cp,
    input  logic                  ds,
    output logic [FRAME_BITS-1:0] par_data,
    output logic                  par_valid,
    output logic                  frame_err,
    output logic [31:0]           disp_data,
    output logic                  disp_valid,
    output logic                  decode_err
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS + 1);
    localparam logic [2:0]    ARM_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sh_sync;
    logic [SYNC_STAGES-1:0] st_sync;
    logic [SYNC_STAGES-1:0] ds_sync;
    logic                   sh_hist;
    logic                   st_hist;
    logic [2:0]             arm_cnt;
    logic                   armed;
    logic                   sh_rise;
    logic                   st_rise;
    logic                   ds_s;

    logic [FRAME_BITS-1:0]  shreg;
    logic [CW-1:0]          bit_cnt;

    frame_t                 frame;
    logic [NIB_W-1:0]       nib;
    logic                   hit;
    logic                   sel_ok;
    logic                   dec_ok;
    logic [DIGITS-1:0]      seen;
    logic [DIGITS-1:0]      seen_next;
    logic [31:0]            disp_next;

    // Edges are only trusted once the whole history was filled after reset.
    assign armed   = (arm_cnt == ARM_DONE);
    assign ds_s    = ds_sync[SYNC_STAGES-1];
    assign sh_rise = armed & sh_sync[SYNC_STAGES-1] & ~sh_hist;
    assign st_rise = armed & st_sync[SYNC_STAGES-1] & ~st_hist;

    // Synchronizers, edge history and post-reset arming counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_sync <= '0;
            st_sync <= '0;
            ds_sync <= '0;
            sh_hist <= 1'b0;
            st_hist <= 1'b0;
            arm_cnt <= '0;
        end else begin
            sh_sync <= {sh_sync[SYNC_STAGES-2:0], sh_cp};
            st_sync <= {st_sync[SYNC_STAGES-2:0], st_cp};
            ds_sync <= {ds_sync[SYNC_STAGES-2:0], ds};
            sh_hist <= sh_sync[SYNC_STAGES-1];
            st_hist <= st_sync[SYNC_STAGES-1];
            if (!armed) arm_cnt <= arm_cnt + 3'd1;
        end
    end

    // Shift register, bit counter and storage latch with 595 semantics.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            par_data  <= '0;
            par_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            par_valid <= st_rise;
            frame_err <= st_rise && (bit_cnt != CNT_FULL);
            if (st_rise) par_data <= shreg;
            if (sh_rise) shreg <= {shreg[FRAME_BITS-2:0], ds_s};
            if (st_rise) begin
                bit_cnt <= sh_rise ? CW'(1) : '0;
            end else if (sh_rise && bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    assign frame  = frame_t'(par_data[15:0]);
    assign sel_ok = (frame.sel != '0) &&
                    ((frame.sel & (frame.sel - SEL_W'(1))) == '0);
    assign dec_ok = hit && sel_ok && !frame_err && !frame.pad;

    seg7_decode u_seg7_decode (
        .seg (frame.seg),
        .nib (nib),
        .hit (hit)
    );

    // Candidate display value and digit coverage for the latched frame.
    always_comb begin
        disp_next = disp_data;
        seen_next = seen | frame.sel;
        for (int i = 0; i < DIGITS; i++) begin
            if (frame.sel[i]) disp_next[NIB_W*i +: NIB_W] = nib;
        end
    end

    // Commit decoded digits and raise completion or error pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            disp_data  <= '0;
            seen       <= '0;
            disp_valid <= 1'b0;
            decode_err <= 1'b0;
        end else begin
            decode_err <= par_valid && !dec_ok;
            disp_valid <= par_valid && dec_ok && (seen_next == '1);
            if (par_valid && dec_ok) begin
                disp_data <= disp_next;
                seen      <= (seen_next == '1) ? '0 : seen_next;
            end
        end
    end

endmodule

// File: tb/tb_hc595_rx.sv
// Bench for hc595_rx: directed 595 traffic with a
// queue-based scoreboard checked by a separate monitor.
module tb_hc595_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sh_cp;
    logic        st_cp;
    logic        ds;
    logic [15:0] par_data;
    logic        par_valid;
    logic        frame_err;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        decode_err;

    typedef struct {
        logic [15:0] data;
        logic        ferr;
    } par_exp_t;

    typedef struct {
        logic        derr;
        logic        dval;
        logic [31:0] disp;
    } dec_exp_t;

    par_exp_t pq[$];
    dec_exp_t dq[$];
    par_exp_t pe;
    dec_exp_t de;

    int checks   = 0;
    int errors   = 0;
    int pv_count = 0;
    int pv_before;
    logic dec_due = 1'b0;
    logic pv_prev = 1'b0;

    hc595_rx #(
        .FRAME_BITS  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sh_cp      (sh_cp),
        .st_cp      (st_cp),
        .ds         (ds),
        .par_data   (par_data),
        .par_valid  (par_valid),
        .frame_err  (frame_err),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .decode_err (decode_err)
    );

    always #10 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Monitor: pops expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        if (reset_n) begin
            if (dec_due) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL dec_unexpected derr=%0b dval=%0b",
                             decode_err, disp_valid);
                end else begin
                    de = dq.pop_front();
                    if (decode_err !== de.derr || disp_valid !== de.dval ||
                        disp_data !== de.disp) begin
                        errors++;
                        $display("FAIL dec got derr=%0b dval=%0b disp=%h exp derr=%0b dval=%0b disp=%h",
                                 decode_err, disp_valid, disp_data,
                                 de.derr, de.dval, de.disp);
                    end
                end
            end else if (decode_err || disp_valid) begin
                checks++;
                errors++;
                $display("FAIL dec_stray derr=%0b dval=%0b exp 0 0",
                         decode_err, disp_valid);
            end
            if (par_valid) begin
                pv_count++;
                checks++;
                if (pv_prev) begin
                    errors++;
                    $display("FAIL par_valid_width got 2 cycles exp 1");
                end else if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL par_stray data=%h", par_data);
                end else begin
                    pe = pq.pop_front();
                    if (par_data !== pe.data || frame_err !== pe.ferr) begin
                        errors++;
                        $display("FAIL par got data=%h ferr=%0b exp data=%h ferr=%0b",
                                 par_data, frame_err, pe.data, pe.ferr);
                    end
                end
            end
            dec_due = par_valid;
            pv_prev = par_valid;
        end else begin
            dec_due = 1'b0;
            pv_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic exp_par(input logic [15:0] d, input logic f);
        par_exp_t p;
        p.data = d;
        p.ferr = f;
        pq.push_back(p);
    endtask

    task automatic exp_dec(input logic e, input logic v, input logic [31:0] d);
        dec_exp_t x;
        x.derr = e;
        x.dval = v;
        x.disp = d;
        dq.push_back(x);
    endtask

    task automatic shift_bit(input logic b);
        ds = b;
        tick(3);
        sh_cp = 1'b1;
        tick(3);
        sh_cp = 1'b0;
        tick(3);
    endtask

    task automatic shift_n(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic latch();
        st_cp = 1'b1;
        tick(3);
        st_cp = 1'b0;
        tick(3);
    endtask

    task automatic send(input logic [31:0] v, input int n);
        shift_n(v, n);
        latch();
    endtask

    initial begin
        reset_n = 1'b0;
        sh_cp   = 1'b0;
        st_cp   = 1'b0;
        ds      = 1'b0;
        tick(3);
        check("rst_par_data", 32'(par_data), 32'h0);
        check("rst_pulses", {28'h0, par_valid, frame_err, disp_valid, decode_err}, 32'h0);
        check("rst_disp", disp_data, 32'h0);
        reset_n = 1'b1;
        tick(6);

        // normal frame, digit0 = 0
        exp_par(16'h4001, 1'b0);
        exp_dec(1'b0, 1'b0, 32'h0000_0000);
        send(32'h4001, 16);

        // short frame: old bit0 of 4001 becomes MSB
        exp_par(16'hF902, 1'b1);
        exp_dec(1'b1, 1'b0, 32'h0000_0000);
        send(32'h7902, 15);

        // bad glyph
        exp_par(16'h7F01, 1'b0);
        exp_dec(1'b1, 1'b0, 32'h0000_0000);
        send(32'h7F01, 16);

        // simultaneous shift + latch, then 15 bits complete the next frame
        exp_par(16'h7902, 1'b0);
        exp_dec(1'b0, 1'b0, 32'h0000_0010);
        exp_par(16'h2404, 1'b0);
        exp_dec(1'b0, 1'b0, 32'h0000_0210);
        shift_n(32'h7902, 16);
        ds = 1'b0;
        tick(3);
        sh_cp = 1'b1;
        st_cp = 1'b1;
        tick(3);
        sh_cp = 1'b0;
        st_cp = 1'b0;
        tick(3);
        send(32'h2404, 15);

        // reset mid-frame with st_cp held high across release
        shift_n(32'hFF, 8);
        pv_before = pv_count;
        reset_n = 1'b0;
        st_cp   = 1'b1;
        tick(1);
        reset_n = 1'b1;
        check("mid_rst_par_data", 32'(par_data), 32'h0);
        check("mid_rst_disp", disp_data, 32'h0);
        tick(10);
        st_cp = 1'b0;
        tick(5);
        check("held_st_no_edge", 32'(pv_count - pv_before), 32'h0);
        exp_par(16'h3008, 1'b0);
        exp_dec(1'b0, 1'b0, 32'h0000_3000);
        send(32'h3008, 16);

        // full scan of 01234567
        exp_par(16'h7801, 1'b0); exp_dec(1'b0, 1'b0, 32'h0000_3007);
        exp_par(16'h0202, 1'b0); exp_dec(1'b0, 1'b0, 32'h0000_3067);
        exp_par(16'h1204, 1'b0); exp_dec(1'b0, 1'b0, 32'h0000_3567);
        exp_par(16'h1908, 1'b0); exp_dec(1'b0, 1'b0, 32'h0000_4567);
        exp_par(16'h3010, 1'b0); exp_dec(1'b0, 1'b0, 32'h0003_4567);
        exp_par(16'h2420, 1'b0); exp_dec(1'b0, 1'b0, 32'h0023_4567);
        exp_par(16'h7940, 1'b0); exp_dec(1'b0, 1'b0, 32'h0123_4567);
        exp_par(16'h4080, 1'b0); exp_dec(1'b0, 1'b1, 32'h0123_4567);
        send(32'h7801, 16);
        send(32'h0202, 16);
        send(32'h1204, 16);
        send(32'h1908, 16);
        send(32'h3010, 16);
        send(32'h2420, 16);
        send(32'h7940, 16);
        send(32'h4080, 16);

        // seen cleared: no new completion; glyph F on digit7
        exp_par(16'h4080, 1'b0); exp_dec(1'b0, 1'b0, 32'h0123_4567);
        exp_par(16'h0E80, 1'b0); exp_dec(1'b0, 1'b0, 32'hF123_4567);
        send(32'h4080, 16);
        send(32'h0E80, 16);

        // pad bit set, sel not one-hot, over-long frame
        exp_par(16'h8001, 1'b0); exp_dec(1'b1, 1'b0, 32'hF123_4567);
        exp_par(16'h4003, 1'b0); exp_dec(1'b1, 1'b0, 32'hF123_4567);
        exp_par(16'h4001, 1'b1); exp_dec(1'b1, 1'b0, 32'hF123_4567);
        send(32'h8001, 16);
        send(32'h4003, 16);
        send(32'h14001, 17);

        for (int i = 0; i < 200 && (pq.size() != 0 || dq.size() != 0); i++)
            tick(1);
        tick(4);
        check("par_queue_drained", pq.size(), 32'h0);
        check("dec_queue_drained", dq.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
